qs_bank_sched: RTL and testbench

The bank scheduler owns the lifecycle state of every sort bank in the quicksort engine. It hands banks, in strict round-robin order, to three clients: the enqueue engine (loads unsorted data), the sort engine and the dequeue engine. A bank can only move IDLE → LOADING → READY → SORTING → SORTED → UNLOADING → IDLE. The scheduler sits between the three engines and the bank-state storage, and it is the only writer of bank status.

---
 rtl/qs_pkg.sv | 13 +
 rtl/qs_bank_sched.sv | 137 +++++++++++++
 tb/tb_qs_bank_sched.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/qs_pkg.sv
// Shared quicksort-engine constants and the bank lifecycle encoding.
package qs_pkg;
  localparam int N = 16;

  typedef enum logic [2:0] {
    BS_IDLE      = 3'd0,
    BS_LOADING   = 3'd1,
    BS_READY     = 3'd2,
    BS_SORTING   = 3'd3,
    BS_SORTED    = 3'd4,
    BS_UNLOADING = 3'd5
  } bank_st_e;
endpackage

// File: rtl/qs_bank_sched.sv
// Round-robin bank lifecycle scheduler for the enqueue, sort and dequeue engines.
// Grant one cycle after req when the bank is in the entry state; otherwise req stalls with no grant.
module qs_bank_sched #(
  parameter int BANKS_N = 4,
  parameter int ID_W    = $clog2(BANKS_N),
  parameter int N_W     = $clog2(qs_pkg::N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_req,
  output logic                   enq_gnt_r,
  output logic [ID_W-1:0]        enq_bank_r,
  input  logic                   enq_done,
  input  logic [N_W-1:0]         enq_n,
  input  logic                   srt_req,
  output logic                   srt_gnt_r,
  output logic [ID_W-1:0]        srt_bank_r,
  input  logic                   srt_done,
  output logic [N_W-1:0]         srt_n_r,
  input  logic                   deq_req,
  output logic                   deq_gnt_r,
  output logic [ID_W-1:0]        deq_bank_r,
  input  logic                   deq_done,
  output logic [N_W-1:0]         deq_n_r,
  output logic [3*BANKS_N-1:0]   status_r,
  output logic                   err_r
);
  import qs_pkg::*;

  typedef enum logic {C_FREE = 1'b0, C_OWN = 1'b1} cl_st_e;

  logic [BANKS_N-1:0][2:0]     status_q, status_d;
  logic [BANKS_N-1:0][N_W-1:0] n_q, n_d;
  logic [2:0][ID_W-1:0]        ptr_q, ptr_d;
  logic [2:0][ID_W-1:0]        bank_q, bank_d;
  cl_st_e                      cl_q [3];
  cl_st_e                      cl_d [3];
  logic [N_W-1:0]              srt_n_q, srt_n_d;
  logic [N_W-1:0]              deq_n_q, deq_n_d;
  logic                        err_q, err_d;
  logic [2:0]                  req_v, done_v;

  // Client index: 0 = enqueue, 1 = sort, 2 = dequeue.
  function automatic logic [2:0] entry_st(input int c);
    case (c)
      0:       return BS_IDLE;
      1:       return BS_READY;
      default: return BS_SORTED;
    endcase
  endfunction

  function automatic logic [2:0] busy_st(input int c);
    case (c)
      0:       return BS_LOADING;
      1:       return BS_SORTING;
      default: return BS_UNLOADING;
    endcase
  endfunction

  function automatic logic [2:0] exit_st(input int c);
    case (c)
      0:       return BS_READY;
      1:       return BS_SORTED;
      default: return BS_IDLE;
    endcase
  endfunction

  assign req_v  = {deq_req, srt_req, enq_req};
  assign done_v = {deq_done, srt_done, enq_done};

  // Every check reads pre-edge status, so a bank freed by one client is never re-granted on the same edge.
  always_comb begin
    status_d = status_q;
    n_d      = n_q;
    ptr_d    = ptr_q;
    bank_d   = bank_q;
    cl_d     = cl_q;
    srt_n_d  = srt_n_q;
    deq_n_d  = deq_n_q;
    err_d    = err_q;
    for (int c = 0; c < 3; c++) begin
      if (cl_q[2'(c)] == C_FREE) begin
        if (done_v[2'(c)]) begin
          err_d = 1'b1;
        end else if (req_v[2'(c)] && status_q[ptr_q[2'(c)]] == entry_st(c)) begin
          status_d[ptr_q[2'(c)]] = busy_st(c);
          cl_d[2'(c)]            = C_OWN;
          bank_d[2'(c)]          = ptr_q[2'(c)];
          if (c == 1) srt_n_d = n_q[ptr_q[2'(c)]];
          if (c == 2) deq_n_d = n_q[ptr_q[2'(c)]];
        end
      end else begin
        if (status_q[bank_q[2'(c)]] != busy_st(c)) begin
          err_d = 1'b1;
        end else if (done_v[2'(c)]) begin
          status_d[bank_q[2'(c)]] = exit_st(c);
          cl_d[2'(c)]             = C_FREE;
          ptr_d[2'(c)]            = ptr_q[2'(c)] + 1'b1;
          if (c == 0) n_d[bank_q[2'(c)]] = enq_n;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      status_q <= '0;
      n_q      <= '0;
      ptr_q    <= '0;
      bank_q   <= '0;
      for (int c = 0; c < 3; c++) cl_q[c] <= C_FREE;
      srt_n_q  <= '0;
      deq_n_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      n_q      <= n_d;
      ptr_q    <= ptr_d;
      bank_q   <= bank_d;
      cl_q     <= cl_d;
      srt_n_q  <= srt_n_d;
      deq_n_q  <= deq_n_d;
      err_q    <= err_d;
    end
  end

  assign enq_gnt_r  = (cl_q[0] == C_OWN);
  assign srt_gnt_r  = (cl_q[1] == C_OWN);
  assign deq_gnt_r  = (cl_q[2] == C_OWN);
  assign enq_bank_r = bank_q[0];
  assign srt_bank_r = bank_q[1];
  assign deq_bank_r = bank_q[2];
  assign srt_n_r    = srt_n_q;
  assign deq_n_r    = deq_n_q;
  assign status_r   = status_q;
  assign err_r      = err_q;
endmodule

// File: tb/tb_qs_bank_sched.sv
// Directed plus randomized bench for qs_bank_sched against a stage-number reference model.
module tb_qs_bank_sched;
  localparam int BANKS_N = 4;
  localparam int ID_W    = $clog2(BANKS_N);
  localparam int N_W     = $clog2(qs_pkg::N);

  logic                 clk;
  logic                 rst_v;
  logic [2:0]           req_v;
  logic [2:0]           done_v;
  logic [N_W-1:0]       enq_n_v;
  logic                 enq_gnt_r, srt_gnt_r, deq_gnt_r;
  logic [ID_W-1:0]      enq_bank_r, srt_bank_r, deq_bank_r;
  logic [N_W-1:0]       srt_n_r, deq_n_r;
  logic [3*BANKS_N-1:0] status_r;
  logic                 err_r;

  int checks = 0;
  int errors = 0;

  // Reference model: a bank's stage number; client c takes stage 2c -> 2c+1 -> (2c+2) mod 6.
  int st   [BANKS_N];
  int nval [BANKS_N];
  int ptr  [3];
  int bank [3];
  bit own  [3];
  int srtn, deqn;
  bit err_m;
  int fifo_q [$];
  bit sb_pend;
  int sb_exp;

  qs_bank_sched #(.BANKS_N(BANKS_N)) dut (
    .clk(clk), .rst(rst_v),
    .enq_req(req_v[0]), .enq_gnt_r(enq_gnt_r), .enq_bank_r(enq_bank_r),
    .enq_done(done_v[0]), .enq_n(enq_n_v),
    .srt_req(req_v[1]), .srt_gnt_r(srt_gnt_r), .srt_bank_r(srt_bank_r),
    .srt_done(done_v[1]), .srt_n_r(srt_n_r),
    .deq_req(req_v[2]), .deq_gnt_r(deq_gnt_r), .deq_bank_r(deq_bank_r),
    .deq_done(done_v[2]), .deq_n_r(deq_n_r),
    .status_r(status_r), .err_r(err_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int old [BANKS_N];
    sb_pend = 1'b0;
    if (!rst_v) begin
      for (int b = 0; b < BANKS_N; b++) begin st[b] = 0; nval[b] = 0; end
      for (int c = 0; c < 3; c++) begin ptr[c] = 0; bank[c] = 0; own[c] = 1'b0; end
      srtn = 0; deqn = 0; err_m = 1'b0;
      fifo_q.delete();
      return;
    end
    old = st;
    for (int c = 0; c < 3; c++) begin
      if (!own[c]) begin
        if (done_v[c]) err_m = 1'b1;
        else if (req_v[c] && old[ptr[c]] == 2 * c) begin
          own[c] = 1'b1;
          bank[c] = ptr[c];
          st[ptr[c]] = 2 * c + 1;
          if (c == 1) srtn = nval[ptr[c]];
          if (c == 2) begin
            deqn = nval[ptr[c]];
            if (fifo_q.size() > 0) begin sb_exp = fifo_q.pop_front(); sb_pend = 1'b1; end
          end
        end
      end else if (done_v[c]) begin
        st[bank[c]] = (2 * c + 2) % 6;
        ptr[c] = (ptr[c] + 1) % BANKS_N;
        own[c] = 1'b0;
        if (c == 0) begin nval[bank[c]] = int'(enq_n_v); fifo_q.push_back(int'(enq_n_v)); end
      end
    end
  endtask

  task automatic compare_all();
    logic [3*BANKS_N-1:0] exp_st;
    for (int b = 0; b < BANKS_N; b++) exp_st[3*b +: 3] = 3'(st[b]);
    check("status", status_r, exp_st);
    check("enq_gnt", enq_gnt_r, own[0]);
    check("srt_gnt", srt_gnt_r, own[1]);
    check("deq_gnt", deq_gnt_r, own[2]);
    check("enq_bank", enq_bank_r, bank[0]);
    check("srt_bank", srt_bank_r, bank[1]);
    check("deq_bank", deq_bank_r, bank[2]);
    check("srt_n", srt_n_r, srtn);
    check("deq_n", deq_n_r, deqn);
    check("err", err_r, err_m);
    if (sb_pend) check("deq_order", deq_n_r, sb_exp);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    rst_v = 1'b0; req_v = '0; done_v = '0; enq_n_v = '0;
    step(); step();
    check("rst_status", status_r, 0);
    rst_v = 1'b1;

    // Single flow through bank 0.
    req_v = 3'b001; step();
    check("flow_enq_gnt", enq_gnt_r, 1);
    check("flow_enq_bank", enq_bank_r, 0);
    req_v = '0; repeat (3) step();
    done_v = 3'b001; enq_n_v = 4'd7; step(); done_v = '0;
    check("flow_ready", status_r[2:0], 2);
    req_v = 3'b010; step(); req_v = '0;
    check("flow_srt_gnt", srt_gnt_r, 1);
    check("flow_srt_n", srt_n_r, 7);
    done_v = 3'b010; step(); done_v = '0;
    req_v = 3'b100; step(); req_v = '0;
    check("flow_deq_n", deq_n_r, 7);
    done_v = 3'b100; step(); done_v = '0;
    check("flow_idle", status_r, 0);

    // Fill every bank; enqueue pointer runs 1,2,3 then wraps to 0.
    for (int i = 0; i < 4; i++) begin
      req_v = 3'b001; step();
      check("full_bank", enq_bank_r, (i + 1) % 4);
      req_v = '0; done_v = 3'b001; enq_n_v = 4'(i + 3); step(); done_v = '0;
    end
    req_v = 3'b001; repeat (3) step();
    check("full_stall", enq_gnt_r, 0);
    req_v = 3'b011; step();
    check("full_srt_bank", srt_bank_r, 1);
    req_v = 3'b001; done_v = 3'b010; step();
    req_v = 3'b101; done_v = '0; step();
    check("full_deq_bank", deq_bank_r, 1);
    req_v = 3'b001; done_v = 3'b100; step(); done_v = '0;
    check("full_still_stalled", enq_gnt_r, 0);
    step();
    check("full_regrant", enq_gnt_r, 1);
    check("full_regrant_bank", enq_bank_r, 1);
    req_v = '0; done_v = 3'b001; step(); done_v = '0;

    // Concurrency: enq owns bank 2, srt bank 1, deq bank 0, all finish together.
    rst_v = 1'b0; step(); rst_v = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_v = 3'b001; step(); req_v = '0;
      done_v = 3'b001; enq_n_v = 4'(9 + i); step(); done_v = '0;
    end
    req_v = 3'b010; step(); req_v = '0;
    done_v = 3'b010; step(); done_v = '0;
    req_v = 3'b111; step(); req_v = '0;
    done_v = 3'b111; enq_n_v = 4'd5; step(); done_v = '0;
    check("conc_status", status_r, 12'h0A0);
    check("conc_err", err_r, 0);

    // Reset with all three clients owning banks.
    req_v = 3'b111; step(); req_v = '0;
    check("mid_all_own", {deq_gnt_r, srt_gnt_r, enq_gnt_r}, 3'b111);
    rst_v = 1'b0; step(); rst_v = 1'b1;
    check("mid_rst_gnts", {deq_gnt_r, srt_gnt_r, enq_gnt_r}, 0);
    check("mid_rst_status", status_r, 0);
    req_v = 3'b001; step(); req_v = '0;
    check("mid_first_bank", enq_bank_r, 0);

    // Protocol error: sort done while sort is free.
    done_v = 3'b010; step(); done_v = '0;
    check("perr_err", err_r, 1);
    check("perr_status", status_r, 12'h001);
    step();
    check("perr_sticky", err_r, 1);

    // Randomized traffic with occasional resets and stray done pulses.
    rst_v = 1'b0; step(); rst_v = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_v = ($urandom_range(0, 399) != 0);
      enq_n_v = N_W'($urandom);
      for (int c = 0; c < 3; c++) begin
        req_v[c]  = ($urandom_range(0, 2) != 0);
        done_v[c] = own[c] ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 599) == 0);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
